// File: rtl/disp_pkg.sv
// Shared display-colour definitions: conversion mode encodings and the 4x4 Bayer
// threshold matrix used for ordered dithering.
package disp_pkg;

   localparam int MODE_TRUNC  = 0;
   localparam int MODE_DITHER = 1;

   typedef logic [3:0] thr_t;

   localparam thr_t BAYER [4][4] = '{
      '{4'd0,  4'd8,  4'd2,  4'd10},
      '{4'd12, 4'd4,  4'd14, 4'd6 },
      '{4'd3,  4'd11, 4'd1,  4'd9 },
      '{4'd15, 4'd7,  4'd13, 4'd5 }
   };

   function automatic thr_t bayer_thr(input logic [1:0] row, input logic [1:0] col);
      return BAYER[row][col];
   endfunction

endpackage

// File: rtl/colr_chan_conv.sv
// Combinational bit-depth conversion of one colour channel: replicate-expand,
// pass-through, truncate or ordered dither with saturation on overflow.
module colr_chan_conv
   import disp_pkg::*;
#(
   parameter int BPC_IN  = 5,
   parameter int BPC_OUT = 8,
   parameter int MODE    = MODE_DITHER
) (
   input  logic [BPC_IN-1:0]  chan_i,
   input  thr_t               thr_i,
   output logic [BPC_OUT-1:0] chan_o
);

   generate
      if (BPC_OUT > BPC_IN) begin : g_expand
         logic unused_thr;
         assign unused_thr = ^thr_i;
         // Repeat the input pattern MSB-first so full scale maps to full scale.
         for (genvar k = 0; k < BPC_OUT; k++) begin : g_bit
            assign chan_o[BPC_OUT-1-k] = chan_i[BPC_IN-1-(k % BPC_IN)];
         end
      end else if (BPC_OUT == BPC_IN) begin : g_pass
         logic unused_thr;
         assign unused_thr = ^thr_i;
         assign chan_o     = chan_i;
      end else if (MODE == MODE_TRUNC) begin : g_trunc
         logic unused_lsb;
         assign unused_lsb = ^{thr_i, chan_i[BPC_IN-BPC_OUT-1:0]};
         assign chan_o     = chan_i[BPC_IN-1 -: BPC_OUT];
      end else begin : g_dither
         localparam int D = BPC_IN - BPC_OUT;

         logic [BPC_IN:0] dv;
         logic [BPC_IN:0] sum;

         function automatic logic [BPC_OUT-1:0] sat_trunc(input logic [BPC_IN:0] s);
            if (s[BPC_IN]) return '1;
            return s[BPC_IN-1:D];
         endfunction

         // Scale the 4-bit threshold onto the D discarded bits.
         if (D >= 4) begin : g_shl
            assign dv = (BPC_IN+1)'(thr_i) << (D - 4);
         end else begin : g_shr
            assign dv = (BPC_IN+1)'(thr_i >> (4 - D));
         end

         assign sum    = {1'b0, chan_i} + dv;
         assign chan_o = sat_trunc(sum);
      end
   endgenerate

endmodule

// File: rtl/disp_colr_adapt.sv
// Two-stage colour depth adapter for a display pipeline: timing and position are
// delayed alongside the converted colour, with an optional per-frame dither rotation.
module disp_colr_adapt
   import disp_pkg::*;
#(
   parameter int BPC_IN   = 5,
   parameter int BPC_OUT  = 8,
   parameter int CORDW    = 16,
   parameter int MODE     = MODE_DITHER,
   parameter int TEMPORAL = 0
) (
   input  logic                     clk_pix,
   input  logic                     rst_pix_n,
   input  logic signed [CORDW-1:0]  in_x,
   input  logic signed [CORDW-1:0]  in_y,
   input  logic                     in_hsync,
   input  logic                     in_vsync,
   input  logic                     in_de,
   input  logic                     in_frame,
   input  logic [BPC_IN-1:0]        in_r,
   input  logic [BPC_IN-1:0]        in_g,
   input  logic [BPC_IN-1:0]        in_b,
   output logic signed [CORDW-1:0]  out_x,
   output logic signed [CORDW-1:0]  out_y,
   output logic                     out_hsync,
   output logic                     out_vsync,
   output logic                     out_de,
   output logic                     out_frame,
   output logic [BPC_OUT-1:0]       out_r,
   output logic [BPC_OUT-1:0]       out_g,
   output logic [BPC_OUT-1:0]       out_b
);

   logic signed [CORDW-1:0] x_p1_q, y_p1_q;
   logic                    hs_p1_q, vs_p1_q, vld_p1_q, fr_p1_q;
   logic [BPC_IN-1:0]       r_p1_q, g_p1_q, b_p1_q;
   thr_t                    thr_p1_q, thr_d;
   logic [1:0]              fcnt_q, fcnt_d, col_d;
   logic [BPC_OUT-1:0]      r_cv, g_cv, b_cv;

   // Threshold uses the pre-increment frame count of the pixel sampled this edge.
   always_comb begin
      fcnt_d = in_frame ? fcnt_q + 2'd1 : fcnt_q;
      col_d  = (TEMPORAL != 0) ? in_x[1:0] + fcnt_q : in_x[1:0];
      thr_d  = bayer_thr(in_y[1:0], col_d);
   end

   // Stage p1: capture pixel, timing and its shared threshold
   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) begin
         fcnt_q   <= '0;
         x_p1_q   <= '0;
         y_p1_q   <= '0;
         hs_p1_q  <= 1'b0;
         vs_p1_q  <= 1'b0;
         vld_p1_q <= 1'b0;
         fr_p1_q  <= 1'b0;
         r_p1_q   <= '0;
         g_p1_q   <= '0;
         b_p1_q   <= '0;
         thr_p1_q <= '0;
      end else begin
         fcnt_q   <= fcnt_d;
         x_p1_q   <= in_x;
         y_p1_q   <= in_y;
         hs_p1_q  <= in_hsync;
         vs_p1_q  <= in_vsync;
         vld_p1_q <= in_de;
         fr_p1_q  <= in_frame;
         r_p1_q   <= in_r;
         g_p1_q   <= in_g;
         b_p1_q   <= in_b;
         thr_p1_q <= thr_d;
      end
   end

   colr_chan_conv #(.BPC_IN(BPC_IN), .BPC_OUT(BPC_OUT), .MODE(MODE)) u_conv_r (
      .chan_i (r_p1_q),
      .thr_i  (thr_p1_q),
      .chan_o (r_cv)
   );

   colr_chan_conv #(.BPC_IN(BPC_IN), .BPC_OUT(BPC_OUT), .MODE(MODE)) u_conv_g (
      .chan_i (g_p1_q),
      .thr_i  (thr_p1_q),
      .chan_o (g_cv)
   );

   colr_chan_conv #(.BPC_IN(BPC_IN), .BPC_OUT(BPC_OUT), .MODE(MODE)) u_conv_b (
      .chan_i (b_p1_q),
      .thr_i  (thr_p1_q),
      .chan_o (b_cv)
   );

   // Stage p2: registered outputs, colour blanked outside active video
   always_ff @(posedge clk_pix or negedge rst_pix_n) begin
      if (!rst_pix_n) begin
         out_x     <= '0;
         out_y     <= '0;
         out_hsync <= 1'b0;
         out_vsync <= 1'b0;
         out_de    <= 1'b0;
         out_frame <= 1'b0;
         out_r     <= '0;
         out_g     <= '0;
         out_b     <= '0;
      end else begin
         out_x     <= x_p1_q;
         out_y     <= y_p1_q;
         out_hsync <= hs_p1_q;
         out_vsync <= vs_p1_q;
         out_de    <= vld_p1_q;
         out_frame <= fr_p1_q;
         out_r     <= vld_p1_q ? r_cv : '0;
         out_g     <= vld_p1_q ? g_cv : '0;
         out_b     <= vld_p1_q ? b_cv : '0;
      end
   end

endmodule

// File: tb/tb_disp_colr_adapt.sv
// Scoreboard bench for disp_colr_adapt: four configurations (expand 5->8, dither,
// temporal dither and truncate 8->5) share timing inputs and hand-computed vectors.
module tb_disp_colr_adapt;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic [15:0] in_x, in_y;
   logic        in_hs, in_vs, in_de, in_fr;
   logic [4:0]  e_in_r, e_in_g, e_in_b;
   logic [7:0]  d_in_r, d_in_g, d_in_b;

   logic [15:0] ex, ey, dx, dy, tx, ty, rx, ry;
   logic        ehs, evs, ede, efr, dhs, dvs, dde, dfr;
   logic        ths, tvs, tde, tfr, rhs, rvs, rde, rfr;
   logic [7:0]  e_r, e_g, e_b;
   logic [4:0]  d_r, d_g, d_b, t_r, t_g, t_b, r_r, r_g, r_b;

   disp_colr_adapt #(.BPC_IN(5), .BPC_OUT(8), .CORDW(16), .MODE(1), .TEMPORAL(0)) u_exp (
      .clk_pix(clk), .rst_pix_n(rst_n), .in_x(in_x), .in_y(in_y),
      .in_hsync(in_hs), .in_vsync(in_vs), .in_de(in_de), .in_frame(in_fr),
      .in_r(e_in_r), .in_g(e_in_g), .in_b(e_in_b),
      .out_x(ex), .out_y(ey), .out_hsync(ehs), .out_vsync(evs), .out_de(ede),
      .out_frame(efr), .out_r(e_r), .out_g(e_g), .out_b(e_b)
   );

   disp_colr_adapt #(.BPC_IN(8), .BPC_OUT(5), .CORDW(16), .MODE(1), .TEMPORAL(0)) u_dth (
      .clk_pix(clk), .rst_pix_n(rst_n), .in_x(in_x), .in_y(in_y),
      .in_hsync(in_hs), .in_vsync(in_vs), .in_de(in_de), .in_frame(in_fr),
      .in_r(d_in_r), .in_g(d_in_g), .in_b(d_in_b),
      .out_x(dx), .out_y(dy), .out_hsync(dhs), .out_vsync(dvs), .out_de(dde),
      .out_frame(dfr), .out_r(d_r), .out_g(d_g), .out_b(d_b)
   );

   disp_colr_adapt #(.BPC_IN(8), .BPC_OUT(5), .CORDW(16), .MODE(1), .TEMPORAL(1)) u_tmp (
      .clk_pix(clk), .rst_pix_n(rst_n), .in_x(in_x), .in_y(in_y),
      .in_hsync(in_hs), .in_vsync(in_vs), .in_de(in_de), .in_frame(in_fr),
      .in_r(d_in_r), .in_g(d_in_g), .in_b(d_in_b),
      .out_x(tx), .out_y(ty), .out_hsync(ths), .out_vsync(tvs), .out_de(tde),
      .out_frame(tfr), .out_r(t_r), .out_g(t_g), .out_b(t_b)
   );

   disp_colr_adapt #(.BPC_IN(8), .BPC_OUT(5), .CORDW(16), .MODE(0), .TEMPORAL(0)) u_trc (
      .clk_pix(clk), .rst_pix_n(rst_n), .in_x(in_x), .in_y(in_y),
      .in_hsync(in_hs), .in_vsync(in_vs), .in_de(in_de), .in_frame(in_fr),
      .in_r(d_in_r), .in_g(d_in_g), .in_b(d_in_b),
      .out_x(rx), .out_y(ry), .out_hsync(rhs), .out_vsync(rvs), .out_de(rde),
      .out_frame(rfr), .out_r(r_r), .out_g(r_g), .out_b(r_b)
   );

   typedef struct {
      int          due;
      logic [15:0] x, y;
      logic        hs, vs, de, fr;
      logic [7:0]  er, eg;
      logic [4:0]  dr, dg, tr, tg, rr, rg;
   } exp_t;

   exp_t sb[$];
   exp_t it;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic idle();
      in_x = '0; in_y = '0; in_hs = 0; in_vs = 0; in_de = 0; in_fr = 0;
      e_in_r = '0; e_in_g = '0; e_in_b = '0;
      d_in_r = '0; d_in_g = '0; d_in_b = '0;
   endtask

   // Drive one pixel on the falling edge; blue inputs follow red, so blue expects red's result.
   task automatic px(input logic [15:0] x, input logic [15:0] y,
                     input logic hs, input logic vs, input logic de, input logic fr,
                     input logic [4:0] ein, input logic [4:0] egin,
                     input logic [7:0] er, input logic [7:0] eg,
                     input logic [7:0] drin, input logic [7:0] dgin,
                     input logic [4:0] dor, input logic [4:0] dog,
                     input logic [4:0] tor, input logic [4:0] tog,
                     input logic [4:0] ror, input logic [4:0] rog);
      exp_t e;
      @(negedge clk);
      in_x = x; in_y = y; in_hs = hs; in_vs = vs; in_de = de; in_fr = fr;
      e_in_r = ein; e_in_g = egin; e_in_b = ein;
      d_in_r = drin; d_in_g = dgin; d_in_b = drin;
      e.due = cyc + 2;
      e.x = x; e.y = y; e.hs = hs; e.vs = vs; e.de = de; e.fr = fr;
      e.er = er; e.eg = eg; e.dr = dor; e.dg = dog;
      e.tr = tor; e.tg = tog; e.rr = ror; e.rg = rog;
      sb.push_back(e);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_e_col"}, {e_r, e_g, e_b}, 64'd0);
      chk({tag, "_e_tim"}, {ex, ey, ehs, evs, ede, efr}, 64'd0);
      chk({tag, "_d_col"}, {d_r, d_g, d_b, t_r, t_g, t_b}, 64'd0);
      chk({tag, "_t_tim"}, {tx, ty, ths, tvs, tde, tfr}, 64'd0);
      chk({tag, "_r_col"}, {r_r, r_g, r_b}, 64'd0);
   endtask

   // Monitor: compare each queued expectation in the cycle its output is due.
   initial begin
      forever begin
         @(posedge clk);
         cyc = cyc + 1;
         #1;
         while (sb.size() != 0 && sb[0].due <= cyc) begin
            it = sb.pop_front();
            if (it.due != cyc) begin
               total++; bad++;
               $display("FAIL late: item due %0d seen at cycle %0d", it.due, cyc);
            end else begin
               chk("e_tim", {ex, ey, ehs, evs, ede, efr}, {it.x, it.y, it.hs, it.vs, it.de, it.fr});
               chk("d_tim", {dx, dy, dhs, dvs, dde, dfr}, {it.x, it.y, it.hs, it.vs, it.de, it.fr});
               chk("t_tim", {tx, ty, ths, tvs, tde, tfr}, {it.x, it.y, it.hs, it.vs, it.de, it.fr});
               chk("r_tim", {rx, ry, rhs, rvs, rde, rfr}, {it.x, it.y, it.hs, it.vs, it.de, it.fr});
               chk("e_r", e_r, it.er);
               chk("e_g", e_g, it.eg);
               chk("e_b", e_b, it.er);
               chk("d_r", d_r, it.dr);
               chk("d_g", d_g, it.dg);
               chk("d_b", d_b, it.dr);
               chk("t_r", t_r, it.tr);
               chk("t_g", t_g, it.tg);
               chk("t_b", t_b, it.tr);
               chk("r_r", r_r, it.rr);
               chk("r_g", r_g, it.rg);
               chk("r_b", r_b, it.rr);
            end
         end
      end
   end

   initial begin
      idle();
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #2;
      chk_zero("rst_init");
      @(negedge clk);
      rst_n = 1'b1;

      //  x        y        hs vs de fr  ein    egin   er     eg     drin   dgin   dor    dog    tor    tog    ror    rog
      px(16'd0,  16'd0,  0, 0, 1, 0, 5'h1F, 5'h00, 8'hFF, 8'h00, 8'h0B, 8'h0F, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01);
      px(16'd1,  16'd0,  1, 0, 1, 0, 5'h10, 5'h0F, 8'h84, 8'h7B, 8'h0B, 8'hF0, 5'h01, 5'h1E, 5'h01, 5'h1E, 5'h01, 5'h1E);
      px(16'd3,  16'd0,  0, 0, 1, 0, 5'h00, 5'h1F, 8'h00, 8'hFF, 8'h0B, 8'h07, 5'h02, 5'h01, 5'h02, 5'h01, 5'h01, 5'h00);
      px(16'd2,  16'd0,  0, 1, 1, 0, 5'h15, 5'h0A, 8'hAD, 8'h52, 8'h0B, 8'h3C, 5'h01, 5'h07, 5'h01, 5'h07, 5'h01, 5'h07);
      // Saturation at t=15: 0xFE+7 and 0xF9+7 both carry out
      px(16'd0,  16'd3,  0, 0, 1, 0, 5'h01, 5'h1E, 8'h08, 8'hF7, 8'hFE, 8'hF9, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F);
      px(16'hFFFC, 16'hFFFF, 0, 0, 1, 0, 5'h1F, 5'h00, 8'hFF, 8'h00, 8'h0B, 8'h00, 5'h02, 5'h00, 5'h02, 5'h00, 5'h01, 5'h00);
      px(16'hFFFD, 16'hFFFE, 0, 0, 1, 0, 5'h02, 5'h1D, 8'h10, 8'hEF, 8'h0B, 8'h1A, 5'h02, 5'h03, 5'h02, 5'h03, 5'h01, 5'h03);
      // Blanking: colour forced to zero, timing still delayed
      px(16'd5,  16'd7,  1, 1, 0, 0, 5'h1F, 5'h1F, 8'h00, 8'h00, 8'hFF, 8'hFF, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00);
      // Frame pulses: temporal instance walks columns 0,1,2,3 then wraps to 0
      px(16'd0,  16'd0,  0, 1, 1, 1, 5'h10, 5'h0F, 8'h84, 8'h7B, 8'h0F, 8'h0B, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01);
      px(16'd0,  16'd0,  0, 0, 1, 0, 5'h10, 5'h0F, 8'h84, 8'h7B, 8'h0B, 8'h0F, 5'h01, 5'h01, 5'h01, 5'h02, 5'h01, 5'h01);
      px(16'd0,  16'd0,  0, 0, 1, 1, 5'h10, 5'h0F, 8'h84, 8'h7B, 8'h0F, 8'h0B, 5'h01, 5'h01, 5'h02, 5'h01, 5'h01, 5'h01);
      px(16'd0,  16'd0,  1, 0, 1, 1, 5'h10, 5'h0F, 8'h84, 8'h7B, 8'h0E, 8'h0B, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01);
      px(16'd0,  16'd0,  0, 0, 1, 1, 5'h10, 5'h0F, 8'h84, 8'h7B, 8'h0E, 8'h0B, 5'h01, 5'h01, 5'h02, 5'h02, 5'h01, 5'h01);
      px(16'd0,  16'd0,  0, 0, 1, 0, 5'h10, 5'h0F, 8'h84, 8'h7B, 8'h0F, 8'h0B, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01);
      px(16'd1,  16'd1,  0, 0, 1, 1, 5'h10, 5'h0F, 8'h84, 8'h7B, 8'h0F, 8'h0B, 5'h02, 5'h01, 5'h02, 5'h01, 5'h01, 5'h01);

      // Active video in flight when reset hits mid-line
      px(16'd2,  16'd2,  0, 0, 1, 0, 5'h1F, 5'h1F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F);
      px(16'd2,  16'd2,  0, 0, 1, 0, 5'h1F, 5'h1F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F);
      px(16'd2,  16'd2,  0, 0, 1, 0, 5'h1F, 5'h1F, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F);
      #2;
      chk("pre_rst_de", {ede, e_r}, {1'b1, 8'hFF});
      rst_n = 1'b0;
      sb.delete();
      #1;
      chk_zero("rst_mid");
      @(posedge clk);
      #2;
      chk_zero("rst_hold");
      @(negedge clk);
      idle();
      rst_n = 1'b1;

      // Temporal instance must be back at column 0 after reset
      px(16'd0,  16'd0,  0, 0, 1, 0, 5'h1F, 5'h00, 8'hFF, 8'h00, 8'h0F, 8'h0B, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01, 5'h01);
      px(16'd1,  16'd0,  1, 0, 1, 0, 5'h10, 5'h0F, 8'h84, 8'h7B, 8'h0B, 8'hF0, 5'h01, 5'h1E, 5'h01, 5'h1E, 5'h01, 5'h1E);
      @(negedge clk);
      idle();

      for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clk);
      #3;
      if (sb.size() != 0) begin
         total++; bad++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
